// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StPar,
        StStop
    } rx_state_e;

    // Clocks per oversample tick, clamped so the divider always runs.
    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud,
                                             input int unsigned oversample);
        int unsigned d;
        d = clk_freq / (baud * oversample);
        return (d == 0) ? 1 : d;
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample tick generator: clock divider plus oversample counter with
// mid-bit sample and decision strobes.
module uart_os_tick #(
    parameter int unsigned DIV        = 1,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned OS_W       = $clog2(OVERSAMPLE)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            restart,
    input  logic            enable,
    output logic            tick,
    output logic [OS_W-1:0] os_cnt,
    output logic            samp,
    output logic            decide
);

    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned M     = OVERSAMPLE / 2;

    logic [DIV_W-1:0] div_q, div_d;
    logic [OS_W-1:0]  os_q, os_d;

    assign tick   = enable && (div_q == DIV_W'(DIV - 1));
    assign os_cnt = os_q;

    // Three samples straddle the bit centre; the last one also decides the bit.
    assign samp   = tick && ((os_q == OS_W'(M - 1)) || (os_q == OS_W'(M)) ||
                             (os_q == OS_W'(M + 1)));
    assign decide = tick && (os_q == OS_W'(M + 1));

    always_comb begin
        div_d = div_q;
        os_d  = os_q;
        if (restart) begin
            div_d = '0;
            os_d  = '0;
        end else if (enable) begin
            div_d = tick ? '0 : div_q + 1'b1;
            if (tick) begin
                os_d = (os_q == OS_W'(OVERSAMPLE - 1)) ? '0 : os_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
            os_q  <= '0;
        end else begin
            div_q <= div_d;
            os_q  <= os_d;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchroniser, majority-vote bit decision,
// framing FSM and a valid/ready output register with overrun reporting.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 36000000,
    parameter int unsigned UART_BPS   = 9600,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 rx_busy
);

    localparam int unsigned DIV   = calc_div(CLK_FREQ, UART_BPS, OVERSAMPLE);
    localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
    localparam int unsigned CNT_W = $clog2(DATA_BITS);

    logic rxd_meta_q, rxd_s_q, rxd_prev_q;
    logic start_edge;

    rx_state_e state_q, state_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [1:0]           samp_q, samp_d;
    logic                 ferr_acc_q, ferr_acc_d;
    logic                 perr_q, perr_d;

    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 overrun_q, overrun_d;

    logic            restart;
    logic            tick;
    logic [OS_W-1:0] os_cnt;
    logic            samp;
    logic            decide;
    logic            bit_end;
    logic            bit_val;
    logic            frame_done;
    logic            frame_ferr;

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rxd_meta_q <= uart_rxd;
            rxd_s_q    <= rxd_meta_q;
            rxd_prev_q <= rxd_s_q;
        end
    end

    assign start_edge = rxd_prev_q & ~rxd_s_q;

    uart_os_tick #(
        .DIV        (DIV),
        .OVERSAMPLE (OVERSAMPLE),
        .OS_W       (OS_W)
    ) u_os_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .enable  (state_q != StIdle),
        .tick    (tick),
        .os_cnt  (os_cnt),
        .samp    (samp),
        .decide  (decide)
    );

    assign bit_end = tick && (os_cnt == OS_W'(OVERSAMPLE - 1));

    // samp_q holds the two earlier window samples; the third is the live input.
    assign samp_d  = samp ? {samp_q[0], rxd_s_q} : samp_q;
    assign bit_val = majority3(samp_q[1], samp_q[0], rxd_s_q);

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        ferr_acc_d = ferr_acc_q;
        perr_d     = perr_q;
        restart    = 1'b0;
        frame_done = 1'b0;
        frame_ferr = ferr_acc_q;

        unique case (state_q)
            StIdle: begin
                if (start_edge) begin
                    restart    = 1'b1;
                    state_d    = StStart;
                    bit_cnt_d  = '0;
                    ferr_acc_d = 1'b0;
                    perr_d     = 1'b0;
                end
            end
            StStart: begin
                if (decide && bit_val) begin
                    state_d = StIdle;
                end else if (bit_end) begin
                    state_d   = StData;
                    bit_cnt_d = '0;
                end
            end
            StData: begin
                if (decide) begin
                    shreg_d[bit_cnt_q] = bit_val;
                end
                if (bit_end) begin
                    if (bit_cnt_q == CNT_W'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != PAR_NONE) ? StPar : StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            StPar: begin
                if (decide) begin
                    perr_d = (PARITY == PAR_EVEN) ? ((^shreg_q) ^ bit_val)
                                                  : ~((^shreg_q) ^ bit_val);
                end
                if (bit_end) begin
                    state_d   = StStop;
                    bit_cnt_d = '0;
                end
            end
            StStop: begin
                if (decide) begin
                    if (!bit_val) begin
                        ferr_acc_d = 1'b1;
                    end
                    // Finish at the last decision so a back-to-back start edge is not missed.
                    if (bit_cnt_q == CNT_W'(STOP_BITS - 1)) begin
                        frame_done = 1'b1;
                        frame_ferr = ferr_acc_q | ~bit_val;
                        state_d    = StIdle;
                    end
                end else if (bit_end) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;
        overrun_d    = 1'b0;

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
        if (frame_done) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d    = shreg_q;
                frame_err_d  = frame_ferr;
                parity_err_d = (PARITY != PAR_NONE) && perr_q;
                rx_valid_d   = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            samp_q       <= 2'b11;
            ferr_acc_q   <= 1'b0;
            perr_q       <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            samp_q       <= samp_d;
            ferr_acc_q   <= ferr_acc_d;
            perr_q       <= perr_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;
    assign rx_busy    = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: three instances (8N1, 8E1, 7N2) at 16 clks per bit.
module tb_uart_rx_param;

    logic clk = 1'b0;
    logic rst;
    logic rx_ready;
    logic ser_line;
    int   cur_sel;

    always #5 clk = ~clk;

    logic       rxd_a, rxd_b, rxd_c;
    logic [7:0] data_a, data_b;
    logic [6:0] data_c;
    logic       vld [3];
    logic       ferr [3];
    logic       perr [3];
    logic       ovr [3];
    logic       busy [3];
    logic [8:0] rd [3];

    assign rxd_a = (cur_sel == 0) ? ser_line : 1'b1;
    assign rxd_b = (cur_sel == 1) ? ser_line : 1'b1;
    assign rxd_c = (cur_sel == 2) ? ser_line : 1'b1;
    assign rd[0] = {1'b0, data_a};
    assign rd[1] = {1'b0, data_b};
    assign rd[2] = {2'b00, data_c};

    uart_rx_param #(.CLK_FREQ(1600000), .UART_BPS(100000), .DATA_BITS(8), .PARITY(0),
                    .STOP_BITS(1), .OVERSAMPLE(16)) u_dut_8n1 (
        .clk(clk), .rst(rst), .uart_rxd(rxd_a), .rx_data(data_a), .rx_valid(vld[0]),
        .rx_ready(rx_ready), .frame_err(ferr[0]), .parity_err(perr[0]), .overrun(ovr[0]),
        .rx_busy(busy[0]));

    uart_rx_param #(.CLK_FREQ(1600000), .UART_BPS(100000), .DATA_BITS(8), .PARITY(2),
                    .STOP_BITS(1), .OVERSAMPLE(16)) u_dut_8e1 (
        .clk(clk), .rst(rst), .uart_rxd(rxd_b), .rx_data(data_b), .rx_valid(vld[1]),
        .rx_ready(rx_ready), .frame_err(ferr[1]), .parity_err(perr[1]), .overrun(ovr[1]),
        .rx_busy(busy[1]));

    uart_rx_param #(.CLK_FREQ(1600000), .UART_BPS(100000), .DATA_BITS(7), .PARITY(0),
                    .STOP_BITS(2), .OVERSAMPLE(16)) u_dut_7n2 (
        .clk(clk), .rst(rst), .uart_rxd(rxd_c), .rx_data(data_c), .rx_valid(vld[2]),
        .rx_ready(rx_ready), .frame_err(ferr[2]), .parity_err(perr[2]), .overrun(ovr[2]),
        .rx_busy(busy[2]));

    // Scoreboard of accepted words and overrun pulses per instance.
    int         acc_cnt [3];
    int         ovr_cnt [3];
    logic [8:0] last_data [3];
    logic       last_ferr [3];
    logic       last_perr [3];

    initial begin
        for (int i = 0; i < 3; i++) begin
            acc_cnt[i] = 0;
            ovr_cnt[i] = 0;
            last_data[i] = '0;
            last_ferr[i] = 1'b0;
            last_perr[i] = 1'b0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (vld[i] && rx_ready) begin
                acc_cnt[i]   = acc_cnt[i] + 1;
                last_data[i] = rd[i];
                last_ferr[i] = ferr[i];
                last_perr[i] = perr[i];
            end
            if (ovr[i]) ovr_cnt[i] = ovr_cnt[i] + 1;
        end
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        ser_line = 1'b1;
        step(n);
    endtask

    // Drives n bits LSB first, 16 clks each; glitch_idx pulls one clk low at offset 9.
    task automatic drive_bits(input logic [15:0] bits, input int n, input int glitch_idx);
        for (int b = 0; b < n; b++) begin
            for (int t = 0; t < 16; t++) begin
                ser_line = (b == glitch_idx && t == 9) ? 1'b0 : bits[b];
                step(1);
            end
        end
    endtask

    typedef struct {
        int         sel;
        logic [8:0] data;
        int         nd;
        bit         par_en;
        logic       par_bit;
        logic       stop_val;
        int         ns;
        int         glitch;
        logic [8:0] exp_data;
        logic       exp_ferr;
        logic       exp_perr;
    } vec_t;

    task automatic build_frame(input vec_t v, output logic [15:0] bits, output int n);
        bits = '0;
        n = 0;
        bits[n] = 1'b0;
        n++;
        for (int i = 0; i < v.nd; i++) begin
            bits[n] = v.data[i];
            n++;
        end
        if (v.par_en) begin
            bits[n] = v.par_bit;
            n++;
        end
        for (int s = 0; s < v.ns; s++) begin
            bits[n] = v.stop_val;
            n++;
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [15:0] bits;
        int          n;
        int          acc0, ovr0;
        acc0 = acc_cnt[v.sel];
        ovr0 = ovr_cnt[v.sel];
        build_frame(v, bits, n);
        ser_line = 1'b1;
        cur_sel  = v.sel;
        drive_bits(bits, n, v.glitch);
        idle(24);
        check({tag, " words"}, acc_cnt[v.sel] - acc0, 1);
        check({tag, " overruns"}, ovr_cnt[v.sel] - ovr0, 0);
        check({tag, " rx_data"}, last_data[v.sel], v.exp_data);
        check({tag, " frame_err"}, last_ferr[v.sel], v.exp_ferr);
        check({tag, " parity_err"}, last_perr[v.sel], v.exp_perr);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t        vecs [7];
    logic [15:0] fbits;
    int          fn;
    int          acc0, ovr0, busy_cnt;

    initial begin
        //          sel data    nd pe pb stop ns glitch exp     ferr perr
        vecs[0] = '{0, 9'h0A5, 8, 0, 0, 1, 1,  1, 9'h0A5, 0, 0};
        vecs[1] = '{1, 9'h003, 8, 1, 1, 1, 1, -1, 9'h003, 0, 1};
        vecs[2] = '{1, 9'h003, 8, 1, 0, 1, 1, -1, 9'h003, 0, 0};
        vecs[3] = '{0, 9'h07E, 8, 0, 0, 0, 1, -1, 9'h07E, 1, 0};
        vecs[4] = '{0, 9'h081, 8, 0, 0, 1, 1, -1, 9'h081, 0, 0};
        vecs[5] = '{1, 9'h007, 8, 1, 1, 1, 1, -1, 9'h007, 0, 0};
        vecs[6] = '{2, 9'h02B, 7, 0, 0, 1, 2, -1, 9'h02B, 0, 0};

        rst      = 1'b1;
        rx_ready = 1'b1;
        ser_line = 1'b1;
        cur_sel  = 0;
        step(4);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset rx_valid[%0d]", i), vld[i], 0);
            check($sformatf("reset rx_data[%0d]", i), rd[i], 0);
            check($sformatf("reset rx_busy[%0d]", i), busy[i], 0);
            check($sformatf("reset frame_err[%0d]", i), ferr[i], 0);
            check($sformatf("reset parity_err[%0d]", i), perr[i], 0);
            check($sformatf("reset overrun[%0d]", i), ovr[i], 0);
        end
        rst = 1'b0;
        idle(8);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Short low pulse: start is rejected at the centre vote.
        cur_sel  = 0;
        acc0     = acc_cnt[0];
        busy_cnt = 0;
        for (int t = 0; t < 44; t++) begin
            ser_line = (t < 4) ? 1'b0 : 1'b1;
            step(1);
            if (busy[0]) busy_cnt++;
        end
        check("false start busy in 8..12", (busy_cnt >= 8 && busy_cnt <= 12), 1);
        check("false start busy clears", busy[0], 0);
        check("false start no word", acc_cnt[0] - acc0, 0);
        run_vec('{0, 9'h03C, 8, 0, 0, 1, 1, -1, 9'h03C, 0, 0}, "after false start");

        // Overrun: hold the first word, drop the second.
        rx_ready = 1'b0;
        acc0     = acc_cnt[0];
        ovr0     = ovr_cnt[0];
        build_frame('{0, 9'h011, 8, 0, 0, 1, 1, -1, 9'h011, 0, 0}, fbits, fn);
        drive_bits(fbits, fn, -1);
        build_frame('{0, 9'h022, 8, 0, 0, 1, 1, -1, 9'h022, 0, 0}, fbits, fn);
        drive_bits(fbits, fn, -1);
        idle(24);
        check("overrun held valid", vld[0], 1);
        check("overrun held data", rd[0], 9'h011);
        check("overrun pulses", ovr_cnt[0] - ovr0, 1);
        check("overrun no accept yet", acc_cnt[0] - acc0, 0);
        rx_ready = 1'b1;
        step(1);
        check("overrun accepted", acc_cnt[0] - acc0, 1);
        check("overrun accepted data", last_data[0], 9'h011);
        check("overrun valid drops", vld[0], 0);
        idle(8);

        // Reset in bit 4 of a 7N2 frame.
        cur_sel = 2;
        acc0    = acc_cnt[2];
        build_frame('{2, 9'h05A, 7, 0, 0, 1, 2, -1, 9'h05A, 0, 0}, fbits, fn);
        drive_bits(fbits, 5, -1);
        ser_line = fbits[5];
        step(8);
        check("mid-frame busy", busy[2], 1);
        rst = 1'b1;
        step(2);
        check("mid-frame rst rx_valid", vld[2], 0);
        check("mid-frame rst rx_data", rd[2], 0);
        check("mid-frame rst rx_busy", busy[2], 0);
        check("mid-frame rst frame_err", ferr[2], 0);
        check("mid-frame rst parity_err", perr[2], 0);
        check("mid-frame rst overrun", ovr[2], 0);
        ser_line = 1'b1;
        rst = 1'b0;
        idle(40);
        check("mid-frame rst no word", acc_cnt[2] - acc0, 0);
        check("mid-frame rst idle", busy[2], 0);
        run_vec('{2, 9'h05A, 7, 0, 0, 1, 2, -1, 9'h05A, 0, 0}, "after reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
